// File: rtl/regfile_access_pkg.sv
// rtl/regfile_access_pkg.sv - shared encodings and helpers for the register file access sequencer
package regfile_access_pkg;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'd0,
        OP_READ   = 2'd1,
        OP_RMW_OR = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE_RD = 3'd1,
        ST_WAIT_RD  = 3'd2,
        ST_ISSUE_WR = 3'd3,
        ST_RESP     = 3'd4
    } state_e;

    // A single-register file still needs a one-bit address port.
    function automatic int addr_width(input int regcount);
        int w;
        w = $clog2(regcount);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/regfile_access_sequencer_if.sv
// rtl/regfile_access_sequencer_if.sv - request/response handshakes and register file strobes
interface regfile_access_sequencer_if
    import regfile_access_pkg::*;
#(
    parameter int P_RegCount = 3,
    parameter int P_BitWidth = 32
);
    localparam int A = addr_width(P_RegCount);

    logic                  In_ReqValid;
    logic                  Out_ReqReady;
    logic [1:0]            In_ReqOp;
    logic [A-1:0]          In_ReqAddr;
    logic [P_BitWidth-1:0] In_ReqData;

    logic                  Out_RespValid;
    logic                  In_RespReady;
    logic [P_BitWidth-1:0] Out_RespData;
    logic                  Out_RespErr;

    logic [A-1:0]          Out_RfAddress;
    logic [P_BitWidth-1:0] Out_RfWriteData;
    logic                  Out_RfWrite;
    logic                  Out_RfRead;
    logic [P_BitWidth-1:0] In_RfReadData;

    modport slave (
        input  In_ReqValid, In_ReqOp, In_ReqAddr, In_ReqData,
        input  In_RespReady, In_RfReadData,
        output Out_ReqReady, Out_RespValid, Out_RespData, Out_RespErr,
        output Out_RfAddress, Out_RfWriteData, Out_RfWrite, Out_RfRead
    );

    modport master (
        output In_ReqValid, In_ReqOp, In_ReqAddr, In_ReqData,
        output In_RespReady, In_RfReadData,
        input  Out_ReqReady, Out_RespValid, Out_RespData, Out_RespErr,
        input  Out_RfAddress, Out_RfWriteData, Out_RfWrite, Out_RfRead
    );

endinterface

// File: rtl/regfile_resp_buffer.sv
// rtl/regfile_resp_buffer.sv - one-entry valid/ready holding register for response data and error
module regfile_resp_buffer #(
    parameter int P_BitWidth = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [P_BitWidth-1:0] i_data,
    input  logic                  i_err,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [P_BitWidth-1:0] o_data,
    output logic                  o_err
);

    logic                  r_valid;
    logic [P_BitWidth-1:0] r_data;
    logic                  r_err;

    // Contents are cleared on the handshake so idle outputs read back as zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_err   <= i_err;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_err   = r_err;

endmodule

// File: rtl/regfile_access_sequencer.sv
// rtl/regfile_access_sequencer.sv - sequences single-word write/read/read-modify-OR requests onto a register file
module regfile_access_sequencer
    import regfile_access_pkg::*;
#(
    parameter int P_RegCount = 3,
    parameter int P_BitWidth = 32
) (
    input  logic                       In_Clock,
    input  logic                       In_Reset,
    regfile_access_sequencer_if.slave  bus
);

    localparam int            A            = addr_width(P_RegCount);
    localparam logic [A:0]    LP_REG_COUNT = (A+1)'(P_RegCount);

    state_e                r_state;
    state_e                w_next_state;
    op_e                   r_op;
    logic [A-1:0]          r_addr;
    logic [P_BitWidth-1:0] r_wdata;
    logic [P_BitWidth-1:0] r_rd_data;

    logic                  w_accept;
    logic                  w_req_bad;
    logic                  w_rf_read;
    logic                  w_rf_write;
    logic                  w_rf_active;
    logic                  w_buf_load;
    logic [P_BitWidth-1:0] w_buf_data;
    logic                  w_buf_err;
    logic                  w_resp_valid;

    // Extra MSB keeps the compare honest when P_RegCount is a power of two.
    assign w_req_bad = ({1'b0, bus.In_ReqAddr} >= LP_REG_COUNT) || (bus.In_ReqOp == OP_RSVD);

    always_ff @(posedge In_Clock or posedge In_Reset) begin
        if (In_Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_rf_read    = 1'b0;
        w_rf_write   = 1'b0;
        w_buf_load   = 1'b0;
        w_buf_data   = '0;
        w_buf_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.In_ReqValid) begin
                    w_accept = 1'b1;
                    if (w_req_bad) begin
                        w_next_state = ST_RESP;
                        w_buf_load   = 1'b1;
                        w_buf_err    = 1'b1;
                    end else if (bus.In_ReqOp == OP_WRITE) begin
                        w_next_state = ST_ISSUE_WR;
                    end else begin
                        w_next_state = ST_ISSUE_RD;
                    end
                end
            end
            ST_ISSUE_RD: begin
                w_rf_read    = 1'b1;
                w_next_state = ST_WAIT_RD;
            end
            ST_WAIT_RD: begin
                if (r_op == OP_RMW_OR) begin
                    w_next_state = ST_ISSUE_WR;
                end else begin
                    w_next_state = ST_RESP;
                    w_buf_load   = 1'b1;
                    w_buf_data   = bus.In_RfReadData;
                end
            end
            ST_ISSUE_WR: begin
                w_rf_write   = 1'b1;
                w_next_state = ST_RESP;
                w_buf_load   = 1'b1;
                w_buf_data   = (r_op == OP_RMW_OR) ? r_rd_data : '0;
            end
            ST_RESP: begin
                if (w_resp_valid && bus.In_RespReady) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // r_wdata holds the write data or OR-mask until WAIT_RD folds in the read value.
    always_ff @(posedge In_Clock or posedge In_Reset) begin
        if (In_Reset) begin
            r_op      <= OP_WRITE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rd_data <= '0;
        end else if (w_accept) begin
            r_op      <= op_e'(bus.In_ReqOp);
            r_addr    <= bus.In_ReqAddr;
            r_wdata   <= bus.In_ReqData;
            r_rd_data <= '0;
        end else if (r_state == ST_WAIT_RD) begin
            r_rd_data <= bus.In_RfReadData;
            if (r_op == OP_RMW_OR) begin
                r_wdata <= bus.In_RfReadData | r_wdata;
            end
        end
    end

    regfile_resp_buffer #(
        .P_BitWidth (P_BitWidth)
    ) u_resp_buffer (
        .i_clk   (In_Clock),
        .i_rst   (In_Reset),
        .i_load  (w_buf_load),
        .i_data  (w_buf_data),
        .i_err   (w_buf_err),
        .i_ready (bus.In_RespReady),
        .o_valid (w_resp_valid),
        .o_data  (bus.Out_RespData),
        .o_err   (bus.Out_RespErr)
    );

    assign w_rf_active = (r_state == ST_ISSUE_RD) || (r_state == ST_WAIT_RD) || (r_state == ST_ISSUE_WR);

    assign bus.Out_ReqReady    = (r_state == ST_IDLE) && !In_Reset;
    assign bus.Out_RespValid   = w_resp_valid;
    assign bus.Out_RfRead      = w_rf_read;
    assign bus.Out_RfWrite     = w_rf_write;
    assign bus.Out_RfAddress   = w_rf_active ? r_addr : '0;
    assign bus.Out_RfWriteData = w_rf_active ? r_wdata : '0;

endmodule

// File: tb/tb_regfile_access_sequencer.sv
// tb/tb_regfile_access_sequencer.sv - directed self-checking bench for regfile_access_sequencer
module tb_regfile_access_sequencer;
    import regfile_access_pkg::*;

    localparam int LP_REGS = 3;
    localparam int LP_W    = 32;

    logic In_Clock;
    logic In_Reset;

    regfile_access_sequencer_if #(.P_RegCount(LP_REGS), .P_BitWidth(LP_W)) bus ();

    regfile_access_sequencer #(.P_RegCount(LP_REGS), .P_BitWidth(LP_W)) dut (
        .In_Clock (In_Clock),
        .In_Reset (In_Reset),
        .bus      (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          wr_cnt   = 0;
    int          rd_cnt   = 0;
    int          overlap  = 0;
    int          lat;
    int          wr0;
    int          rd0;
    logic [1:0]  last_wa  = '0;
    logic [31:0] last_wd  = '0;
    logic [31:0] mem [4]  = '{default: 32'h0};

    initial In_Clock = 1'b0;
    always #5 In_Clock = ~In_Clock;

    // Register file model: read data appears the cycle after the read strobe.
    always @(posedge In_Clock) begin
        if (bus.Out_RfWrite) begin
            mem[bus.Out_RfAddress] <= bus.Out_RfWriteData;
            wr_cnt  <= wr_cnt + 1;
            last_wa <= bus.Out_RfAddress;
            last_wd <= bus.Out_RfWriteData;
        end
        if (bus.Out_RfRead) begin
            rd_cnt <= rd_cnt + 1;
            bus.In_RfReadData <= mem[bus.Out_RfAddress];
        end
        if (bus.Out_RfRead && bus.Out_RfWrite) begin
            overlap <= overlap + 1;
        end
    end

    task automatic tick();
        @(posedge In_Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic [1:0] op, input logic [1:0] addr, input logic [31:0] data, input string tag);
        check({tag, "_req_ready"}, 32'(bus.Out_ReqReady), 32'd1);
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        bus.In_ReqValid = 1'b1;
        bus.In_ReqOp    = op;
        bus.In_ReqAddr  = addr;
        bus.In_ReqData  = data;
        tick();
        bus.In_ReqValid = 1'b0;
        bus.In_ReqOp    = 2'd0;
        bus.In_ReqAddr  = 2'd0;
        bus.In_ReqData  = 32'h0;
        lat = 1;
        while (!bus.Out_RespValid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic respond(input string tag);
        bus.In_RespReady = 1'b1;
        tick();
        bus.In_RespReady = 1'b0;
        check({tag, "_resp_cleared"}, 32'(bus.Out_RespValid), 32'd0);
        check({tag, "_back_idle"}, 32'(bus.Out_ReqReady), 32'd1);
    endtask

    task automatic expect_resp(input string tag, input int exp_lat, input logic [31:0] exp_data,
                               input logic exp_err, input int exp_wr, input int exp_rd);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, bus.Out_RespData, exp_data);
        check({tag, "_err"}, 32'(bus.Out_RespErr), 32'(exp_err));
        check({tag, "_wr_strobes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
        check({tag, "_rd_strobes"}, 32'(rd_cnt - rd0), 32'(exp_rd));
    endtask

    initial begin
        In_Reset         = 1'b1;
        bus.In_ReqValid  = 1'b0;
        bus.In_ReqOp     = 2'd0;
        bus.In_ReqAddr   = 2'd0;
        bus.In_ReqData   = 32'h0;
        bus.In_RespReady = 1'b0;
        tick();
        tick();
        check("rst_req_ready", 32'(bus.Out_ReqReady), 32'd0);
        check("rst_resp_valid", 32'(bus.Out_RespValid), 32'd0);
        check("rst_resp_data", bus.Out_RespData, 32'h0);
        check("rst_resp_err", 32'(bus.Out_RespErr), 32'd0);
        check("rst_rf_write", 32'(bus.Out_RfWrite), 32'd0);
        check("rst_rf_read", 32'(bus.Out_RfRead), 32'd0);
        check("rst_rf_addr", 32'(bus.Out_RfAddress), 32'd0);
        In_Reset = 1'b0;
        #1;
        check("post_rst_ready", 32'(bus.Out_ReqReady), 32'd1);
        tick();

        request(2'd0, 2'd1, 32'hDEADBEEF, "wr1");
        expect_resp("wr1", 2, 32'h0, 1'b0, 1, 0);
        check("wr1_addr", 32'(last_wa), 32'd1);
        check("wr1_wdata", last_wd, 32'hDEADBEEF);
        respond("wr1");

        request(2'd1, 2'd1, 32'h0, "rd1");
        expect_resp("rd1", 3, 32'hDEADBEEF, 1'b0, 0, 1);
        respond("rd1");

        request(2'd0, 2'd2, 32'h000000F0, "wr2");
        expect_resp("wr2", 2, 32'h0, 1'b0, 1, 0);
        respond("wr2");

        request(2'd2, 2'd2, 32'h0000000F, "rmw2");
        expect_resp("rmw2", 4, 32'h000000F0, 1'b0, 1, 1);
        check("rmw2_addr", 32'(last_wa), 32'd2);
        check("rmw2_wdata", last_wd, 32'h000000FF);
        respond("rmw2");

        request(2'd1, 2'd2, 32'h0, "rd2");
        expect_resp("rd2", 3, 32'h000000FF, 1'b0, 0, 1);
        respond("rd2");

        request(2'd1, 2'd3, 32'h0, "rd_oob");
        expect_resp("rd_oob", 1, 32'h0, 1'b1, 0, 0);
        respond("rd_oob");

        request(2'd3, 2'd0, 32'h12345678, "rsvd");
        expect_resp("rsvd", 1, 32'h0, 1'b1, 0, 0);
        respond("rsvd");

        request(2'd1, 2'd1, 32'h0, "stall");
        expect_resp("stall", 3, 32'hDEADBEEF, 1'b0, 0, 1);
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_valid", 32'(bus.Out_RespValid), 32'd1);
            check("stall_data", bus.Out_RespData, 32'hDEADBEEF);
            check("stall_req_ready", 32'(bus.Out_ReqReady), 32'd0);
        end
        check("stall_no_wr", 32'(wr_cnt - wr0), 32'd0);
        check("stall_no_rd", 32'(rd_cnt - rd0), 32'd0);
        respond("stall");

        wr0 = wr_cnt;
        bus.In_ReqValid = 1'b1;
        bus.In_ReqOp    = 2'd2;
        bus.In_ReqAddr  = 2'd0;
        bus.In_ReqData  = 32'h00000001;
        tick();
        bus.In_ReqValid = 1'b0;
        bus.In_ReqData  = 32'h0;
        tick();
        check("abort_in_wait_rd", bus.Out_RfWriteData, 32'h00000001);
        In_Reset = 1'b1;
        #1;
        check("abort_rf_wdata", bus.Out_RfWriteData, 32'h0);
        check("abort_rf_write", 32'(bus.Out_RfWrite), 32'd0);
        check("abort_rf_read", 32'(bus.Out_RfRead), 32'd0);
        check("abort_req_ready", 32'(bus.Out_ReqReady), 32'd0);
        check("abort_resp_valid", 32'(bus.Out_RespValid), 32'd0);
        tick();
        tick();
        In_Reset = 1'b0;
        #1;
        check("abort_release_ready", 32'(bus.Out_ReqReady), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_resp", 32'(bus.Out_RespValid), 32'd0);
        end
        check("abort_no_write", 32'(wr_cnt - wr0), 32'd0);

        request(2'd1, 2'd0, 32'h0, "rd0");
        expect_resp("rd0", 3, 32'h0, 1'b0, 0, 1);
        respond("rd0");

        check("no_rd_wr_overlap", 32'(overlap), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_access_sequencer.md
Name: regfile_access_sequencer

Overview:
- Upstream command front-end for the N-bit M-wide register file.
- Accepts single-word requests (write, read, read-modify-OR) over a valid/ready handshake.
- Sequences the register file's address/write/read strobes and returns one response per request over a second valid/ready handshake.
- Range-checks addresses, so out-of-range or reserved requests never reach the register file.

Parameters:
- P_RegCount, 3, number of registers in the downstream register file.
- P_BitWidth, 32, data width per register.
- Address width A = $clog2(P_RegCount), minimum 1.

Ports:
- In_Clock  in  1  single clock, rising edge.
- In_Reset  in  1  reset, asynchronous, active-high.
- In_ReqValid  in  1  request present.
- Out_ReqReady  out  1  sequencer can accept a request.
- In_ReqOp  in  2  0=WRITE, 1=READ, 2=RMW_OR, 3=reserved.
- In_ReqAddr  in  A  target register index.
- In_ReqData  in  P_BitWidth  write data, or OR-mask for RMW_OR.
- Out_RespValid  out  1  response present.
- In_RespReady  in  1  consumer accepts response.
- Out_RespData  out  P_BitWidth  read data (READ/RMW_OR returns the pre-modify value); 0 for WRITE/error.
- Out_RespErr  out  1  request rejected.
- Out_RfAddress  out  A  to register file address.
- Out_RfWriteData  out  P_BitWidth  to register file write data.
- Out_RfWrite  out  1  register file write strobe, one cycle.
- Out_RfRead  out  1  register file read strobe, one cycle.
- In_RfReadData  in  P_BitWidth  register file read data, valid the cycle after Out_RfRead.

Behaviour:
- Reset (async, immediate): state IDLE, Out_ReqReady=0 while In_Reset high, all other outputs 0, request/response registers cleared.
- States: IDLE, ISSUE_RD, WAIT_RD, ISSUE_WR, RESP.
- IDLE: Out_ReqReady=1. On In_ReqValid&Out_ReqReady, capture op/addr/data:
  - addr>=P_RegCount or op==3 -> RESP with Err=1, Data=0, no register-file strobe.
  - WRITE -> ISSUE_WR.
  - READ or RMW_OR -> ISSUE_RD.
- ISSUE_RD: Out_RfRead=1 for exactly one cycle, Out_RfAddress=captured addr -> WAIT_RD.
- WAIT_RD: sample In_RfReadData into response data.
  - READ -> RESP.
  - RMW_OR -> write data = sample | mask, then ISSUE_WR.
- ISSUE_WR: Out_RfWrite=1 for exactly one cycle, Out_RfAddress and Out_RfWriteData stable -> RESP.
- RESP: Out_RespValid=1, data/err held stable until In_RespReady. On handshake -> IDLE.
- Out_ReqReady=0 in every non-IDLE state. One outstanding request, no overlap.
- Out_RfRead and Out_RfWrite are never high in the same cycle.
- Out_RfAddress and Out_RfWriteData are 0 outside ISSUE_*/WAIT_RD.
- Latency, request handshake to Out_RespValid: WRITE 2 cycles, READ 3 cycles, RMW_OR 4 cycles, error 1 cycle.
- Back-to-back: a new request is accepted the cycle after the response handshake (IDLE cycle). Throughput is 1 request per latency+1 cycles, assuming zero response backpressure.
- Response stalled indefinitely: state holds RESP, no register-file activity.
- Reset mid-operation: a pending write strobe is aborted. A write already strobed is not undone. No response is produced for the aborted request.
- Widths: OR is bitwise at P_BitWidth. Address compare is unsigned at A bits, so with P_RegCount a power of two no address is out of range.

Decomposition:
- Shared package regfile_access_pkg:
  - op encodings: OP_WRITE, OP_READ, OP_RMW_OR, OP_RSVD;
  - state enum;
  - address-width function (max(1, $clog2(P_RegCount))).
- Sub-module: regfile_resp_buffer, a one-entry valid/ready output holding register for data/err.
- FSM and datapath stay in the top module.

Test Plan:
- WRITE addr1 data 0xDEADBEEF -> Out_RfWrite pulse 1 cycle at addr1 with 0xDEADBEEF; RespValid 2 cycles after accept, Err=0, Data=0.
- READ addr1, model returns 0xDEADBEEF -> Out_RfRead pulse, RespData=0xDEADBEEF 3 cycles after accept.
- RMW_OR addr2, stored 0x0000_00F0, mask 0x0000_000F -> write of 0x0000_00FF to addr2; RespData=0x0000_00F0; latency 4.
- READ addr3 with P_RegCount=3, then op=3 addr0 -> each gives Err=1, Data=0, latency 1, no Rf strobes.
- Hold In_RespReady=0 for 10 cycles after a READ -> RespValid/Data stable, ReqReady=0, no Rf strobes; release -> handshake, IDLE next cycle.
- Assert In_Reset in WAIT_RD of an RMW_OR -> outputs 0 immediately, no Out_RfWrite; after release, ReqReady=1 the first cycle after reset deasserts, with no response issued.
